// File: rtl/aes_host_pkg.sv
// Shared types and constants for the AES-128 host-side initiator.
//   host_state_t : controller states
//   host_cmd_t   : latched command payload (direction + key-present flag)
package aes_host_pkg;

    localparam int unsigned AES_BLOCK_BYTES = 16;
    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTE_CNT_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_DATA,
        START,
        WAIT_CORE,
        CAPTURE,
        UNLOAD
    } host_state_t;

    typedef struct packed {
        logic encrypt;
        logic new_key;
    } host_cmd_t;

endpackage

// File: rtl/aes_block_serdes.sv
// 128-bit block register with parallel load, MSB-first byte shift and a
// 4-bit byte counter.
//   load_i/load_data_i : parallel load, also clears the byte counter
//   shift_i/byte_i     : shift left by one byte, byte_i enters at the bottom
//   data_o             : full register
//   byte_o             : most-significant byte (next byte to emit)
//   cnt_o              : bytes shifted since the last load / wrap
//   last_o             : counter sits on the final byte of the block
module aes_block_serdes
    import aes_host_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_i,
    input  logic [AES_BLOCK_W-1:0] load_data_i,
    input  logic                   shift_i,
    input  logic [BYTE_W-1:0]      byte_i,
    output logic [AES_BLOCK_W-1:0] data_o,
    output logic [BYTE_W-1:0]      byte_o,
    output logic [BYTE_CNT_W-1:0]  cnt_o,
    output logic                   last_o
);

    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic [BYTE_CNT_W-1:0]  cnt_q, cnt_d;

    // Load wins over shift; the counter wraps naturally after byte 15.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            data_d = load_data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            data_d = {data_q[AES_BLOCK_W-BYTE_W-1:0], byte_i};
            cnt_d  = BYTE_CNT_W'(cnt_q + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o = data_q;
    assign byte_o = data_q[AES_BLOCK_W-1 -: BYTE_W];
    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == BYTE_CNT_W'(AES_BLOCK_BYTES - 1));

endmodule

// File: rtl/aes_host_if.sv
// Host-side initiator for the AES-128 core controller.
//   cmd_*      : command handshake (encrypt/decrypt, key-present flag)
//   in_*       : byte stream in, optional 16-byte key then 16-byte block
//   out_*      : 16 result bytes out, MSB first, out_last on byte 15
//   core_*     : start pulse, keyChange, selCypher, key and block to the
//                core; done/result back from it
//   busy       : controller not idle
//   err_*      : one-cycle pulses for core timeout / missing key
module aes_host_if
    import aes_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_encrypt,
    input  logic                   cmd_new_key,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BYTE_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [BYTE_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   core_start,
    output logic                   core_key_change,
    output logic                   core_sel_cypher,
    output logic [AES_BLOCK_W-1:0] core_key,
    output logic [AES_BLOCK_W-1:0] core_din,
    input  logic                   core_done,
    input  logic [AES_BLOCK_W-1:0] core_dout,
    output logic                   busy,
    output logic                   err_timeout,
    output logic                   err_no_key
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    host_state_t            state_q, state_d;
    host_cmd_t              cmd_q, cmd_d;
    logic                   key_loaded_q, key_loaded_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   in_ready_q, in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   core_start_q, core_start_d;
    logic                   core_key_change_q, core_key_change_d;
    logic                   core_sel_cypher_q, core_sel_cypher_d;
    logic [AES_BLOCK_W-1:0] core_key_q, core_key_d;
    logic [AES_BLOCK_W-1:0] core_din_q, core_din_d;
    logic                   err_timeout_q, err_timeout_d;
    logic                   err_no_key_q, err_no_key_d;

    logic                   in_load, in_shift, out_load, out_shift;
    logic [AES_BLOCK_W-1:0] in_blk, in_next, out_blk;
    logic [BYTE_W-1:0]      in_head;
    logic [BYTE_CNT_W-1:0]  in_cnt, out_cnt, out_cnt_nxt;
    logic                   in_last, out_last_byte;
    logic                   unused_serdes;

    // Key/data assembly path
    aes_block_serdes u_in_path (
        .clk         (clk),
        .reset       (reset),
        .load_i      (in_load),
        .load_data_i ('0),
        .shift_i     (in_shift),
        .byte_i      (in_data),
        .data_o      (in_blk),
        .byte_o      (in_head),
        .cnt_o       (in_cnt),
        .last_o      (in_last)
    );

    // Result unload path
    aes_block_serdes u_out_path (
        .clk         (clk),
        .reset       (reset),
        .load_i      (out_load),
        .load_data_i (core_dout),
        .shift_i     (out_shift),
        .byte_i      ('0),
        .data_o      (out_blk),
        .byte_o      (out_data),
        .cnt_o       (out_cnt),
        .last_o      (out_last_byte)
    );

    assign unused_serdes = ^{in_head, in_cnt, out_blk};

    // Block value including the byte being accepted this cycle
    assign in_next = {in_blk[AES_BLOCK_W-BYTE_W-1:0], in_data};

    // Next-state and output decode
    always_comb begin
        state_d           = state_q;
        cmd_d             = cmd_q;
        key_loaded_d      = key_loaded_q;
        key_d             = key_q;
        tmo_d             = tmo_q;
        core_key_change_d = core_key_change_q;
        core_sel_cypher_d = core_sel_cypher_q;
        core_key_d        = core_key_q;
        core_din_d        = core_din_q;
        err_timeout_d     = 1'b0;
        err_no_key_d      = 1'b0;
        in_load           = 1'b0;
        in_shift          = 1'b0;
        out_load          = 1'b0;
        out_shift         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d   = '{encrypt: cmd_encrypt, new_key: cmd_new_key};
                    in_load = 1'b1;
                    if (!cmd_new_key && !key_loaded_q) begin
                        err_no_key_d = 1'b1;
                    end else if (cmd_new_key) begin
                        state_d = LOAD_KEY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
            end
            LOAD_KEY: begin
                if (in_valid && in_ready_q) begin
                    in_shift = 1'b1;
                    if (in_last) begin
                        key_d        = in_next;
                        key_loaded_d = 1'b1;
                        state_d      = LOAD_DATA;
                    end
                end
            end
            LOAD_DATA: begin
                // Core-facing registers load on entry so they are valid in START
                if (in_valid && in_ready_q) begin
                    in_shift = 1'b1;
                    if (in_last) begin
                        core_key_d        = key_q;
                        core_din_d        = in_next;
                        core_key_change_d = cmd_q.new_key;
                        core_sel_cypher_d = cmd_q.encrypt;
                        state_d           = START;
                    end
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_CORE;
            end
            WAIT_CORE: begin
                tmo_d = TMO_W'(tmo_q + 1'b1);
                // done wins over a coincident timeout
                if (core_done) begin
                    state_d = CAPTURE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    key_loaded_d  = 1'b0;
                    state_d       = IDLE;
                end
            end
            CAPTURE: begin
                out_load = 1'b1;
                state_d  = UNLOAD;
            end
            UNLOAD: begin
                if (out_valid_q && out_ready) begin
                    out_shift = 1'b1;
                    if (out_last_byte) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags decoded from the next state so they register in step
        cmd_ready_d  = (state_d == IDLE);
        in_ready_d   = (state_d == LOAD_KEY) || (state_d == LOAD_DATA);
        out_valid_d  = (state_d == UNLOAD);
        busy_d       = (state_d != IDLE);
        core_start_d = (state_d == START);

        if (out_load) begin
            out_cnt_nxt = '0;
        end else if (out_shift) begin
            out_cnt_nxt = BYTE_CNT_W'(out_cnt + 1'b1);
        end else begin
            out_cnt_nxt = out_cnt;
        end
        out_last_d = (state_d == UNLOAD) && (out_cnt_nxt == BYTE_CNT_W'(AES_BLOCK_BYTES - 1));
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= IDLE;
            cmd_q             <= '0;
            key_loaded_q      <= 1'b0;
            key_q             <= '0;
            tmo_q             <= '0;
            cmd_ready_q       <= 1'b0;
            in_ready_q        <= 1'b0;
            out_valid_q       <= 1'b0;
            out_last_q        <= 1'b0;
            busy_q            <= 1'b0;
            core_start_q      <= 1'b0;
            core_key_change_q <= 1'b0;
            core_sel_cypher_q <= 1'b0;
            core_key_q        <= '0;
            core_din_q        <= '0;
            err_timeout_q     <= 1'b0;
            err_no_key_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            cmd_q             <= cmd_d;
            key_loaded_q      <= key_loaded_d;
            key_q             <= key_d;
            tmo_q             <= tmo_d;
            cmd_ready_q       <= cmd_ready_d;
            in_ready_q        <= in_ready_d;
            out_valid_q       <= out_valid_d;
            out_last_q        <= out_last_d;
            busy_q            <= busy_d;
            core_start_q      <= core_start_d;
            core_key_change_q <= core_key_change_d;
            core_sel_cypher_q <= core_sel_cypher_d;
            core_key_q        <= core_key_d;
            core_din_q        <= core_din_d;
            err_timeout_q     <= err_timeout_d;
            err_no_key_q      <= err_no_key_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_last        = out_last_q;
    assign busy            = busy_q;
    assign core_start      = core_start_q;
    assign core_key_change = core_key_change_q;
    assign core_sel_cypher = core_sel_cypher_q;
    assign core_key        = core_key_q;
    assign core_din        = core_din_q;
    assign err_timeout     = err_timeout_q;
    assign err_no_key      = err_no_key_q;

endmodule

// File: tb/tb_aes_host_if.sv
// Directed bench for aes_host_if. dut_a uses the default timeout, dut_t a
// timeout of 8 cycles; both share stimulus and 'sel' picks the one checked.
module tb_aes_host_if;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, cmd_valid, cmd_encrypt, cmd_new_key;
    logic         in_valid, out_ready, core_done;
    logic [7:0]   in_data;
    logic [127:0] core_dout;

    logic         a_cmd_ready, a_in_ready, a_out_valid, a_out_last, a_core_start;
    logic         a_core_key_change, a_core_sel_cypher, a_busy, a_err_timeout, a_err_no_key;
    logic [7:0]   a_out_data;
    logic [127:0] a_core_key, a_core_din;
    logic         t_cmd_ready, t_in_ready, t_out_valid, t_out_last, t_core_start;
    logic         t_core_key_change, t_core_sel_cypher, t_busy, t_err_timeout, t_err_no_key;
    logic [7:0]   t_out_data;
    logic [127:0] t_core_key, t_core_din;

    aes_host_if dut_a (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_encrypt(cmd_encrypt), .cmd_new_key(cmd_new_key),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_last(a_out_last),
        .core_start(a_core_start), .core_key_change(a_core_key_change),
        .core_sel_cypher(a_core_sel_cypher), .core_key(a_core_key), .core_din(a_core_din),
        .core_done(core_done), .core_dout(core_dout),
        .busy(a_busy), .err_timeout(a_err_timeout), .err_no_key(a_err_no_key)
    );

    aes_host_if #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(t_cmd_ready),
        .cmd_encrypt(cmd_encrypt), .cmd_new_key(cmd_new_key),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_data(t_out_data), .out_last(t_out_last),
        .core_start(t_core_start), .core_key_change(t_core_key_change),
        .core_sel_cypher(t_core_sel_cypher), .core_key(t_core_key), .core_din(t_core_din),
        .core_done(core_done), .core_dout(core_dout),
        .busy(t_busy), .err_timeout(t_err_timeout), .err_no_key(t_err_no_key)
    );

    bit sel;
    logic         m_cmd_ready, m_in_ready, m_out_valid, m_out_last, m_core_start;
    logic         m_core_key_change, m_core_sel_cypher, m_busy, m_err_timeout, m_err_no_key;
    logic [7:0]   m_out_data;
    logic [127:0] m_core_key, m_core_din;

    assign m_cmd_ready       = sel ? t_cmd_ready       : a_cmd_ready;
    assign m_in_ready        = sel ? t_in_ready        : a_in_ready;
    assign m_out_valid       = sel ? t_out_valid       : a_out_valid;
    assign m_out_last        = sel ? t_out_last        : a_out_last;
    assign m_out_data        = sel ? t_out_data        : a_out_data;
    assign m_core_start      = sel ? t_core_start      : a_core_start;
    assign m_core_key_change = sel ? t_core_key_change : a_core_key_change;
    assign m_core_sel_cypher = sel ? t_core_sel_cypher : a_core_sel_cypher;
    assign m_core_key        = sel ? t_core_key        : a_core_key;
    assign m_core_din        = sel ? t_core_din        : a_core_din;
    assign m_busy            = sel ? t_busy            : a_busy;
    assign m_err_timeout     = sel ? t_err_timeout     : a_err_timeout;
    assign m_err_no_key      = sel ? t_err_no_key      : a_err_no_key;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] key, pt, ct, ct2, junk;
    logic         seen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic enc, input logic nk);
        int n;
        n = 0;
        while (m_cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready", m_cmd_ready, 1'b1);
        cmd_valid   = 1'b1;
        cmd_encrypt = enc;
        cmd_new_key = nk;
        tick();
        cmd_valid   = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] v);
        for (int i = 0; i < 16; i++) begin
            int n;
            n        = 0;
            in_valid = 1'b1;
            in_data  = v[8*(15-i) +: 8];
            while (m_in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (m_in_ready !== 1'b1) chk("wait_in_ready", m_in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Core model: done after 'cycles' wait cycles, result valid the cycle after
    task automatic core_respond(input int cycles, input logic [127:0] dout);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            seen = seen | m_core_start;
        end
        core_done = 1'b1;
        tick();
        seen = seen | m_core_start;
        core_done = 1'b0;
        core_dout = dout;
        tick();
        core_dout = junk;
        chk("single_start", seen, 1'b0);
    endtask

    task automatic recv_block(input logic [127:0] exp);
        for (int i = 0; i < 16; i++) begin
            int n;
            n = 0;
            while (m_out_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            chk($sformatf("out_byte%0d", i), m_out_data, exp[8*(15-i) +: 8]);
            chk($sformatf("out_last%0d", i), m_out_last, (i == 15));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("unload_done_valid", m_out_valid, 1'b0);
        chk("unload_done_busy", m_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        key  = 128'h000102030405060708090a0b0c0d0e0f;
        pt   = 128'h00112233445566778899aabbccddeeff;
        ct   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ct2  = 128'h3925841d02dc09fbdc118597196a0b32;
        junk = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

        sel = 1'b0; reset = 1'b1; cmd_valid = 1'b0; cmd_encrypt = 1'b0; cmd_new_key = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; core_done = 1'b0; core_dout = junk;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", m_cmd_ready, 1'b0);
        chk("rst_in_ready", m_in_ready, 1'b0);
        chk("rst_out_valid", m_out_valid, 1'b0);
        chk("rst_busy", m_busy, 1'b0);
        chk("rst_core_start", m_core_start, 1'b0);
        chk("rst_core_key", m_core_key, 128'h0);
        reset = 1'b0;
        tick();
        chk("idle_cmd_ready", m_cmd_ready, 1'b1);

        // Encrypt with new key
        send_cmd(1'b1, 1'b1);
        chk("t1_busy", m_busy, 1'b1);
        chk("t1_in_ready", m_in_ready, 1'b1);
        send_block(key);
        send_block(pt);
        chk("t1_start", m_core_start, 1'b1);
        chk("t1_key_change", m_core_key_change, 1'b1);
        chk("t1_sel_cypher", m_core_sel_cypher, 1'b1);
        chk("t1_core_key", m_core_key, key);
        chk("t1_core_din", m_core_din, pt);
        core_respond(40, ct);
        recv_block(ct);

        // Decrypt reusing the stored key; only 16 bytes accepted
        send_cmd(1'b0, 1'b0);
        chk("t2_no_err", m_err_no_key, 1'b0);
        chk("t2_in_ready", m_in_ready, 1'b1);
        send_block(ct);
        in_valid = 1'b1;
        chk("t2_in_ready_after16", m_in_ready, 1'b0);
        chk("t2_start", m_core_start, 1'b1);
        chk("t2_key_change", m_core_key_change, 1'b0);
        chk("t2_sel_cypher", m_core_sel_cypher, 1'b0);
        chk("t2_core_key", m_core_key, key);
        chk("t2_core_din", m_core_din, ct);
        core_respond(5, pt);
        in_valid = 1'b0;
        recv_block(pt);

        // Backpressure then reset mid-unload
        send_cmd(1'b1, 1'b0);
        send_block(pt);
        chk("t5_start", m_core_start, 1'b1);
        core_respond(3, ct);
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            chk($sformatf("bp_data%0d", i), m_out_data, ct[8*(15-i) +: 8]);
            tick();
            chk($sformatf("bp_hold%0d", i), m_out_data, ct[8*(15-i) +: 8]);
            chk($sformatf("bp_valid%0d", i), m_out_valid, 1'b1);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", m_out_valid, 1'b0);
        chk("t5_rst_busy", m_busy, 1'b0);
        chk("t5_rst_data", m_out_data, 8'h00);
        tick();
        reset = 1'b0;
        send_cmd(1'b0, 1'b0);
        chk("t5_key_cleared", m_err_no_key, 1'b1);
        tick();
        chk("t5_err_pulse_end", m_err_no_key, 1'b0);

        // No key after reset (short-timeout instance)
        sel = 1'b1;
        send_cmd(1'b0, 1'b0);
        chk("t3_err_no_key", m_err_no_key, 1'b1);
        chk("t3_busy", m_busy, 1'b0);
        chk("t3_in_ready", m_in_ready, 1'b0);
        tick();
        chk("t3_err_pulse_end", m_err_no_key, 1'b0);
        chk("t3_busy2", m_busy, 1'b0);
        chk("t3_in_ready2", m_in_ready, 1'b0);

        // Timeout: 8 WAIT_CORE cycles, pulse on return to IDLE
        send_cmd(1'b1, 1'b1);
        send_block(key);
        send_block(pt);
        chk("t4_start", m_core_start, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | m_err_timeout;
        end
        chk("t4_no_early_tmo", seen, 1'b0);
        chk("t4_busy_waiting", m_busy, 1'b1);
        tick();
        chk("t4_err_timeout", m_err_timeout, 1'b1);
        chk("t4_idle", m_busy, 1'b0);
        chk("t4_cmd_ready", m_cmd_ready, 1'b1);
        tick();
        chk("t4_tmo_pulse_end", m_err_timeout, 1'b0);
        send_cmd(1'b0, 1'b0);
        chk("t4_key_dropped", m_err_no_key, 1'b1);

        // done coincides with the last timeout cycle
        send_cmd(1'b1, 1'b1);
        send_block(key);
        send_block(pt);
        chk("t6_start", m_core_start, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_dout = ct2;
        chk("t6_no_tmo", m_err_timeout, 1'b0);
        chk("t6_busy", m_busy, 1'b1);
        chk("t6_capture_valid", m_out_valid, 1'b0);
        tick();
        core_dout = junk;
        chk("t6_no_tmo2", m_err_timeout, 1'b0);
        chk("t6_unload_valid", m_out_valid, 1'b1);
        recv_block(ct2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
